multicycle_ctrl: RTL

Multi-cycle control unit for the RV32I core: decodes the instruction register, sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, and drives the datapath selects, PC/IR write enables and the memory request handshakes. It sits between the instruction register/branch comparator and the datapath muxes. It adds variable-latency memory, a watchdog, illegal-instruction trapping and a retired-instruction counter, and compiles in optional M-extension sequencing.

---
 rtl/multicycle_ctrl_if.sv | 45 ++++
 rtl/multicycle_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_if.sv
// Handshake/control bundle between multicycle_ctrl and the RV32I datapath.
// master = controller side, slave = datapath/memory side.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      inst_i;
    logic             BrEq_i;
    logic             BrLt_i;
    logic             imem_ack_i;
    logic             dmem_ack_i;
    logic             mdu_done_i;

    logic             RegWEn_o;
    logic             Bsel_o;
    logic             MemRW_o;
    logic             BrUn_o;
    logic             PCSel_o;
    logic             Asel_o;
    logic [3:0]       AluSel_o;
    logic [2:0]       ImmSel_o;
    logic [1:0]       WBSel_o;
    logic             PCWEn_o;
    logic             IRWEn_o;
    logic             imem_req_o;
    logic             dmem_req_o;
    logic             mdu_start_o;
    logic             illegal_o;
    logic             timeout_o;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] instret_o;

    modport master (
        input  inst_i, BrEq_i, BrLt_i, imem_ack_i, dmem_ack_i, mdu_done_i,
        output RegWEn_o, Bsel_o, MemRW_o, BrUn_o, PCSel_o, Asel_o, AluSel_o,
               ImmSel_o, WBSel_o, PCWEn_o, IRWEn_o, imem_req_o, dmem_req_o,
               mdu_start_o, illegal_o, timeout_o, state_o, instret_o
    );

    modport slave (
        output inst_i, BrEq_i, BrLt_i, imem_ack_i, dmem_ack_i, mdu_done_i,
        input  RegWEn_o, Bsel_o, MemRW_o, BrUn_o, PCSel_o, Asel_o, AluSel_o,
               ImmSel_o, WBSel_o, PCWEn_o, IRWEn_o, imem_req_o, dmem_req_o,
               mdu_start_o, illegal_o, timeout_o, state_o, instret_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control unit: decode, FETCH/DECODE/EXEC/MEM/WB sequencing, watchdog, traps.
// Optional M-extension sequencing is compiled in with `define RV32M_EN.
//
// state  | meaning
// FETCH  | imem request outstanding, IR written on ack
// DECODE | legality check of the instruction register
// EXEC   | ALU cycle; branches resolve and retire here
// MEM    | dmem request outstanding; stores retire on ack
// WB     | register write-back, PC update, retire
// MDU    | waiting for multiply/divide result
// TRAP   | absorbing until reset
module multicycle_ctrl #(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 32
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    multicycle_ctrl_if.master  bus
);
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        MDU    = 3'd5,
        TRAP   = 3'd7
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_B   = 4'b1111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] WB_MEM = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_MDU = 2'b11;

    localparam logic [TIMEOUT_W-1:0] TO_LIM = TIMEOUT_W'(TIMEOUT);

    state_t               state_q, state_d;
    logic [TIMEOUT_W-1:0] wd_q, wd_d, wd_inc;
    logic [CNT_W-1:0]     instret_q, instret_d;
    logic                 illegal_q, illegal_d;
    logic                 timeout_q, timeout_d;

    logic [31:0] inst;
    logic [6:0]  opcode, f7;
    logic [2:0]  f3;

    logic       legal, is_branch, is_load, is_store, is_jump, is_mdu;
    logic [3:0] alu_sel;
    logic [2:0] imm_sel;
    logic [1:0] wb_sel;
    logic       a_sel, b_sel, br_un, br_taken;

    logic imem_req, dmem_req, ir_wen, pc_wen, reg_wen, mem_rw, pc_sel;

    assign inst   = bus.inst_i;
    assign opcode = inst[6:0];
    assign f3     = inst[14:12];
    assign f7     = inst[31:25];

    // Static decode: depends only on the instruction register, so it stays
    // stable from DECODE through retire while inst_i is held.
    always_comb begin
        legal     = 1'b0;
        is_branch = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_jump   = 1'b0;
        is_mdu    = 1'b0;
        alu_sel   = ALU_ADD;
        imm_sel   = IMM_I;
        wb_sel    = WB_ALU;
        a_sel     = 1'b0;
        b_sel     = 1'b0;
        br_un     = 1'b0;
        case (opcode)
            OPC_LUI: begin
                legal   = 1'b1;
                imm_sel = IMM_U;
                b_sel   = 1'b1;
                alu_sel = ALU_B;
            end
            OPC_AUIPC: begin
                legal   = 1'b1;
                imm_sel = IMM_U;
                a_sel   = 1'b1;
                b_sel   = 1'b1;
            end
            OPC_JAL: begin
                legal   = 1'b1;
                is_jump = 1'b1;
                imm_sel = IMM_J;
                a_sel   = 1'b1;
                b_sel   = 1'b1;
                wb_sel  = WB_PC4;
            end
            OPC_JALR: begin
                legal   = (f3 == 3'b000);
                is_jump = 1'b1;
                b_sel   = 1'b1;
                wb_sel  = WB_PC4;
            end
            OPC_BRANCH: begin
                legal     = (f3[2:1] != 2'b01);
                is_branch = 1'b1;
                imm_sel   = IMM_B;
                a_sel     = 1'b1;
                b_sel     = 1'b1;
                br_un     = f3[1];
            end
            OPC_LOAD: begin
                legal   = (f3 != 3'b011) && (f3[2:1] != 2'b11);
                is_load = 1'b1;
                b_sel   = 1'b1;
                wb_sel  = WB_MEM;
            end
            OPC_STORE: begin
                legal    = !f3[2] && (f3 != 3'b011);
                is_store = 1'b1;
                imm_sel  = IMM_S;
                b_sel    = 1'b1;
            end
            OPC_OPIMM: begin
                b_sel   = 1'b1;
                alu_sel = {(f3 == 3'b101) && inst[30], f3};
                if (f3 == 3'b001)
                    legal = (f7 == 7'b0000000);
                else if (f3 == 3'b101)
                    legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                else
                    legal = 1'b1;
            end
            OPC_OP: begin
                alu_sel = {inst[30], f3};
                legal   = (f7 == 7'b0000000) ||
                          ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
`ifdef RV32M_EN
                if (f7 == 7'b0000001) begin
                    legal   = 1'b1;
                    is_mdu  = 1'b1;
                    alu_sel = ALU_ADD;
                    wb_sel  = WB_MDU;
                end
`endif
            end
            default: legal = 1'b0;
        endcase
    end

    // f3[2] selects the less-than compare, f3[0] inverts the sense
    assign br_taken = f3[2] ? (bus.BrLt_i ^ f3[0]) : (bus.BrEq_i ^ f3[0]);
    assign wd_inc   = wd_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        ir_wen    = 1'b0;
        pc_wen    = 1'b0;
        reg_wen   = 1'b0;
        mem_rw    = 1'b0;
        pc_sel    = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ack_i) begin
                    ir_wen  = 1'b1;
                    state_d = DECODE;
                end else if (wd_inc == TO_LIM) begin
                    state_d   = TRAP;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_inc;
                end
            end
            DECODE: begin
                if (legal) begin
                    state_d = EXEC;
                end else begin
                    state_d   = TRAP;
                    illegal_d = 1'b1;
                end
            end
            EXEC: begin
                if (is_branch) begin
                    pc_wen  = 1'b1;
                    pc_sel  = br_taken;
                    state_d = FETCH;
                end else if (is_load || is_store) begin
                    state_d = MEM;
                end else if (is_mdu) begin
                    state_d = MDU;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                mem_rw   = is_store;
                if (bus.dmem_ack_i) begin
                    if (is_store) begin
                        pc_wen  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (wd_inc == TO_LIM) begin
                    state_d   = TRAP;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_inc;
                end
            end
            WB: begin
                reg_wen = 1'b1;
                pc_wen  = 1'b1;
                pc_sel  = is_jump;
                state_d = FETCH;
            end
            MDU: begin
`ifdef RV32M_EN
                if (bus.mdu_done_i)
                    state_d = WB;
`else
                state_d = TRAP;
`endif
            end
            TRAP:    state_d = TRAP;
            default: state_d = TRAP;
        endcase
        if (state_d != state_q)
            wd_d = '0;
    end

    assign instret_d = instret_q + CNT_W'(pc_wen);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= FETCH;
            wd_q      <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

`ifdef RV32M_EN
    logic mdu_start_q, mdu_start_d;
    assign mdu_start_d = (state_q == EXEC) && (state_d == MDU);

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            mdu_start_q <= 1'b0;
        else
            mdu_start_q <= mdu_start_d;
    end

    assign bus.mdu_start_o = rst_ni & mdu_start_q;
`else
    assign bus.mdu_start_o = 1'b0;
`endif

    // Every output is forced low while reset is held, including the fetch request.
    assign bus.imem_req_o = rst_ni & imem_req;
    assign bus.dmem_req_o = rst_ni & dmem_req;
    assign bus.IRWEn_o    = rst_ni & ir_wen;
    assign bus.PCWEn_o    = rst_ni & pc_wen;
    assign bus.RegWEn_o   = rst_ni & reg_wen;
    assign bus.MemRW_o    = rst_ni & mem_rw;
    assign bus.PCSel_o    = rst_ni & pc_sel;
    assign bus.Asel_o     = rst_ni & a_sel;
    assign bus.Bsel_o     = rst_ni & b_sel;
    assign bus.BrUn_o     = rst_ni & br_un;
    assign bus.AluSel_o   = rst_ni ? alu_sel : 4'd0;
    assign bus.ImmSel_o   = rst_ni ? imm_sel : 3'd0;
    assign bus.WBSel_o    = rst_ni ? wb_sel  : 2'd0;
    assign bus.illegal_o  = rst_ni & illegal_q;
    assign bus.timeout_o  = rst_ni & timeout_q;
    assign bus.state_o    = rst_ni ? state_q : 3'd0;
    assign bus.instret_o  = rst_ni ? instret_q : '0;

    logic unused_bits;
    assign unused_bits = ^{inst[24:15], inst[11:7], bus.mdu_done_i};
endmodule
